// File: rtl/data_island_scheduler_if.sv
// Bus between the data island scheduler and its neighbours: window requests
// from the timing generator, packet requests/payloads from the packet sources,
// and the packet contents / period code towards the serializer and TMDS mux.
// The master side is the environment; the slave side is the scheduler.
interface data_island_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic                     islandAllowed;
    logic [4:0]               islandSlots;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*24-1:0]    pktHeader;
    logic [NUM_REQ*224-1:0]   pktBody;
    logic [NUM_REQ-1:0]       grant;
    logic                     isFirstPacketClock;
    logic [23:0]              header;
    logic [55:0]              subpacket0;
    logic [55:0]              subpacket1;
    logic [55:0]              subpacket2;
    logic [55:0]              subpacket3;
    logic [2:0]               phase;
    logic [4:0]               packetsSent;

    modport master (
        output islandAllowed, islandSlots, req, pktHeader, pktBody,
        input  grant, isFirstPacketClock, header,
        input  subpacket0, subpacket1, subpacket2, subpacket3,
        input  phase, packetsSent
    );

    modport slave (
        input  islandAllowed, islandSlots, req, pktHeader, pktBody,
        output grant, isFirstPacketClock, header,
        output subpacket0, subpacket1, subpacket2, subpacket3,
        output phase, packetsSent
    );
endinterface

// File: rtl/data_island_scheduler.sv
// HDMI data island scheduler.
// Opens a data island when the timing generator offers a window and at least
// one packet source is pending, walks PREAMBLE (8) / LEAD_GUARD (2) /
// PACKET (32 per packet) / TRAIL_GUARD (2), and shares the packet serializer
// between the sources. The payload for each packet is captured into output
// registers on the packet's first clock and held for all 32 clocks.
// Optional feature macro: DATA_ISLAND_SCHEDULER_FIXED_PRIORITY_EN
//   defined   -> fixed priority arbitration (lowest index wins, no pointer)
//   undefined -> round-robin arbitration starting after the last winner
module data_island_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_PACKETS = 18
) (
    input logic                    clock,
    input logic                    reset,
    data_island_scheduler_if.slave bus
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HDR_W  = 24;
    localparam int BODY_W = 224;
    localparam int SP_W   = 56;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_PREAMBLE    = 3'd1,
        S_LEAD_GUARD  = 3'd2,
        S_PACKET      = 3'd3,
        S_TRAIL_GUARD = 3'd4
    } state_t;

    // Period code seen by the TMDS channel mux for a given FSM state.
    function automatic logic [2:0] phase_code(input state_t s);
        logic [2:0] code;
        case (s)
            S_IDLE:        code = 3'd0;
            S_PREAMBLE:    code = 3'd1;
            S_LEAD_GUARD:  code = 3'd2;
            S_PACKET:      code = 3'd3;
            S_TRAIL_GUARD: code = 3'd4;
            default:       code = 3'd0;
        endcase
        return code;
    endfunction

    state_t              state_r;
    state_t              state_next_s;
    logic [4:0]          cnt_r;
    logic [4:0]          cnt_next_s;
    logic [4:0]          slots_r;
    logic [4:0]          slots_next_s;
    logic [4:0]          sent_r;
    logic [4:0]          sent_next_s;
    logic                start_pkt_s;
    logic                any_req_s;
    logic [4:0]          clamp_s;

    logic                win_valid_s;
    logic [IDX_W-1:0]    win_idx_s;
    logic [HDR_W-1:0]    win_hdr_s;
    logic [BODY_W-1:0]   win_body_s;
    logic [NUM_REQ-1:0]  grant_next_s;

    logic [NUM_REQ-1:0]  grant_r;
    logic                first_r;
    logic [2:0]          phase_r;
    logic [HDR_W-1:0]    header_r;
    logic [SP_W-1:0]     sp0_r;
    logic [SP_W-1:0]     sp1_r;
    logic [SP_W-1:0]     sp2_r;
    logic [SP_W-1:0]     sp3_r;

`ifndef DATA_ISLAND_SCHEDULER_FIXED_PRIORITY_EN
    logic [IDX_W-1:0]    last_r;
`endif

    assign any_req_s = |bus.req;
    // A window larger than the HDMI packet limit is trimmed to the limit.
    assign clamp_s   = (bus.islandSlots > 5'(MAX_PACKETS)) ? 5'(MAX_PACKETS)
                                                           : bus.islandSlots;

    // Select the winning requester and its payload; first hit in search order wins.
    always_comb begin
        int   idx;
        logic hit;
        idx         = 0;
        hit         = 1'b0;
        win_valid_s = 1'b0;
        win_idx_s   = '0;
        win_hdr_s   = '0;
        win_body_s  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef DATA_ISLAND_SCHEDULER_FIXED_PRIORITY_EN
            idx = k;
`else
            idx = (int'(last_r) + 1 + k) % NUM_REQ;
`endif
            hit         = !win_valid_s && bus.req[idx];
            win_idx_s   = hit ? IDX_W'(idx) : win_idx_s;
            win_hdr_s   = hit ? bus.pktHeader[idx*HDR_W +: HDR_W] : win_hdr_s;
            win_body_s  = hit ? bus.pktBody[idx*BODY_W +: BODY_W] : win_body_s;
            win_valid_s = win_valid_s | hit;
        end
    end

    // One-hot grant for a packet start that found a requester; null packets grant nobody.
    always_comb begin
        grant_next_s = '0;
        if (start_pkt_s && win_valid_s) begin
            grant_next_s[win_idx_s] = 1'b1;
        end else begin
            grant_next_s = '0;
        end
    end

    // Next-state logic: phase lengths, packet starts and slot bookkeeping.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r + 5'd1;
        slots_next_s = slots_r;
        sent_next_s  = sent_r;
        start_pkt_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                cnt_next_s = 5'd0;
                if (bus.islandAllowed && any_req_s && (clamp_s != 5'd0)) begin
                    state_next_s = S_PREAMBLE;
                    slots_next_s = clamp_s;
                    sent_next_s  = 5'd0;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_PREAMBLE: begin
                if (cnt_r == 5'd7) begin
                    state_next_s = S_LEAD_GUARD;
                    cnt_next_s   = 5'd0;
                end else begin
                    state_next_s = S_PREAMBLE;
                end
            end
            S_LEAD_GUARD: begin
                // The first packet is always sent, as a null packet if nobody asks.
                if (cnt_r == 5'd1) begin
                    state_next_s = S_PACKET;
                    cnt_next_s   = 5'd0;
                    start_pkt_s  = 1'b1;
                    slots_next_s = slots_r - 5'd1;
                    sent_next_s  = sent_r + 5'd1;
                end else begin
                    state_next_s = S_LEAD_GUARD;
                end
            end
            S_PACKET: begin
                if (cnt_r == 5'd31) begin
                    cnt_next_s = 5'd0;
                    if ((slots_r != 5'd0) && any_req_s) begin
                        state_next_s = S_PACKET;
                        start_pkt_s  = 1'b1;
                        slots_next_s = slots_r - 5'd1;
                        sent_next_s  = sent_r + 5'd1;
                    end else begin
                        state_next_s = S_TRAIL_GUARD;
                    end
                end else begin
                    state_next_s = S_PACKET;
                end
            end
            S_TRAIL_GUARD: begin
                if (cnt_r == 5'd1) begin
                    state_next_s = S_IDLE;
                    cnt_next_s   = 5'd0;
                end else begin
                    state_next_s = S_TRAIL_GUARD;
                end
            end
            default: begin
                state_next_s = S_IDLE;
                cnt_next_s   = 5'd0;
            end
        endcase
    end

    // FSM state, phase counter and per-island slot/packet counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
            cnt_r   <= 5'd0;
            slots_r <= 5'd0;
            sent_r  <= 5'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            slots_r <= slots_next_s;
            sent_r  <= sent_next_s;
        end
    end

    // Registered outputs; payload only reloads on a packet's first clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_r  <= '0;
            first_r  <= 1'b0;
            phase_r  <= 3'd0;
            header_r <= '0;
            sp0_r    <= '0;
            sp1_r    <= '0;
            sp2_r    <= '0;
            sp3_r    <= '0;
        end else begin
            grant_r <= grant_next_s;
            first_r <= start_pkt_s;
            phase_r <= phase_code(state_next_s);
            if (start_pkt_s) begin
                header_r <= win_valid_s ? win_hdr_s : '0;
                sp0_r    <= win_valid_s ? win_body_s[0*SP_W +: SP_W] : '0;
                sp1_r    <= win_valid_s ? win_body_s[1*SP_W +: SP_W] : '0;
                sp2_r    <= win_valid_s ? win_body_s[2*SP_W +: SP_W] : '0;
                sp3_r    <= win_valid_s ? win_body_s[3*SP_W +: SP_W] : '0;
            end
        end
    end

`ifndef DATA_ISLAND_SCHEDULER_FIXED_PRIORITY_EN
    // Round-robin pointer: remembers the last granted requester.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_r <= IDX_W'(NUM_REQ - 1);
        end else if (start_pkt_s && win_valid_s) begin
            last_r <= win_idx_s;
        end
    end
`endif

    assign bus.grant              = grant_r;
    assign bus.isFirstPacketClock = first_r;
    assign bus.phase              = phase_r;
    assign bus.packetsSent        = sent_r;
    assign bus.header             = header_r;
    assign bus.subpacket0         = sp0_r;
    assign bus.subpacket1         = sp1_r;
    assign bus.subpacket2         = sp2_r;
    assign bus.subpacket3         = sp3_r;

endmodule

// File: tb/tb_data_island_scheduler.sv
// Directed bench for data_island_scheduler (NUM_REQ = 4, MAX_PACKETS = 18).
// Cycle k is observed 1 time unit after the k-th rising edge following the
// cycle in which islandAllowed is driven high.
module tb_data_island_scheduler;

`ifdef DATA_ISLAND_SCHEDULER_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clock;
    logic reset;
    int   total;
    int   bad;

    data_island_scheduler_if #(.NUM_REQ(4)) dif ();

    data_island_scheduler #(
        .NUM_REQ    (4),
        .MAX_PACKETS(18)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (dif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [23:0] hdr_of(input int i);
        return 24'hC0DE00 | 24'(i + 1);
    endfunction

    function automatic logic [55:0] sp_of(input int i, input int j);
        return 56'h5A000000000000 | 56'((j + 1) << 8) | 56'(i + 1);
    endfunction

    function automatic logic [2:0] exp_phase(input int c, input int n);
        if (c <= 8)              return 3'd1;
        else if (c <= 10)        return 3'd2;
        else if (c <= 10 + 32*n) return 3'd3;
        else if (c <= 12 + 32*n) return 3'd4;
        else                     return 3'd0;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Opens a window and checks phase/grant/first/payload every cycle of an
    // n-packet island. Winner of packet k: (base + k % period) % 4.
    task automatic run_island(input logic [4:0] slots, input int n, input int base,
                              input int period, input bit nogrant,
                              input int drop_cyc, input int busy_cyc);
        int         k;
        int         idx;
        bit         first;
        bit         in_pkt;
        logic [3:0] eg;
        dif.islandSlots   = slots;
        dif.islandAllowed = 1'b1;
        step();
        dif.islandAllowed = 1'b0;
        for (int c = 1; c <= 13 + 32*n; c++) begin
            in_pkt = (c >= 11) && (c < 11 + 32*n);
            k      = in_pkt ? (c - 11) / 32 : 0;
            idx    = (base + (k % period)) % 4;
            first  = in_pkt && (((c - 11) % 32) == 0);
            eg     = (first && !nogrant) ? 4'(1 << idx) : 4'b0000;
            chk($sformatf("phase c=%0d", c), 64'(dif.phase), 64'(exp_phase(c, n)));
            chk($sformatf("grant c=%0d", c), 64'(dif.grant), 64'(eg));
            chk($sformatf("first c=%0d", c), 64'(dif.isFirstPacketClock), 64'(first));
            if (in_pkt) begin
                chk($sformatf("header c=%0d", c), 64'(dif.header),
                    nogrant ? 64'd0 : 64'(hdr_of(idx)));
                chk($sformatf("sent c=%0d", c), 64'(dif.packetsSent), 64'(k + 1));
            end
            if (first) begin
                chk($sformatf("sp0 c=%0d", c), 64'(dif.subpacket0), nogrant ? 64'd0 : 64'(sp_of(idx, 0)));
                chk($sformatf("sp1 c=%0d", c), 64'(dif.subpacket1), nogrant ? 64'd0 : 64'(sp_of(idx, 1)));
                chk($sformatf("sp2 c=%0d", c), 64'(dif.subpacket2), nogrant ? 64'd0 : 64'(sp_of(idx, 2)));
                chk($sformatf("sp3 c=%0d", c), 64'(dif.subpacket3), nogrant ? 64'd0 : 64'(sp_of(idx, 3)));
            end
            if (c == drop_cyc) dif.req = 4'b0000;
            dif.islandAllowed = (c == busy_cyc);
            if (c < 13 + 32*n) step();
        end
        dif.islandAllowed = 1'b0;
        chk("packetsSent end", 64'(dif.packetsSent), 64'(n));
    endtask

    initial begin
        total             = 0;
        bad               = 0;
        reset             = 1'b1;
        dif.islandAllowed = 1'b0;
        dif.islandSlots   = 5'd0;
        dif.req           = 4'b0000;
        dif.pktHeader     = '0;
        dif.pktBody       = '0;
        for (int i = 0; i < 4; i++) begin
            dif.pktHeader[i*24 +: 24] = hdr_of(i);
            for (int j = 0; j < 4; j++) begin
                dif.pktBody[i*224 + j*56 +: 56] = sp_of(i, j);
            end
        end
        step();
        step();

        // reset state
        chk("rst phase", 64'(dif.phase), 64'd0);
        chk("rst grant", 64'(dif.grant), 64'd0);
        chk("rst first", 64'(dif.isFirstPacketClock), 64'd0);
        chk("rst sent", 64'(dif.packetsSent), 64'd0);
        chk("rst header", 64'(dif.header), 64'd0);
        chk("rst sp0", 64'(dif.subpacket0), 64'd0);
        chk("rst sp3", 64'(dif.subpacket3), 64'd0);
        reset = 1'b0;
        step();

        // round-robin, 6 slots, all requesters held
        dif.req = 4'b1111;
        run_island(5'd6, 6, 0, FIXED ? 1 : 4, 1'b0, -1, -1);
        step();

        // slot clamp: 25 requested, 18 sent
        dif.req = 4'b1111;
        run_island(5'd25, 18, FIXED ? 0 : 2, FIXED ? 1 : 4, 1'b0, -1, -1);
        step();

        // single packet, req dropped after grant, busy pulse in PACKET ignored
        dif.req = 4'b0001;
        run_island(5'd5, 1, 0, 1, 1'b0, 11, 20);
        step();

        // null packet: req withdrawn during preamble
        dif.req = 4'b0001;
        run_island(5'd5, 1, 0, 1, 1'b1, 5, -1);
        step();

        // zero slots: no island
        dif.req           = 4'b1111;
        dif.islandSlots   = 5'd0;
        dif.islandAllowed = 1'b1;
        step();
        dif.islandAllowed = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            chk($sformatf("slots0 phase c=%0d", c), 64'(dif.phase), 64'd0);
            chk($sformatf("slots0 grant c=%0d", c), 64'(dif.grant), 64'd0);
            step();
        end

        // asynchronous reset at cycle 50 of an island
        dif.req           = 4'b1111;
        dif.islandSlots   = 5'd5;
        dif.islandAllowed = 1'b1;
        step();
        dif.islandAllowed = 1'b0;
        for (int c = 2; c <= 50; c++) step();
        chk("mid phase before reset", 64'(dif.phase), 64'd3);
        reset = 1'b1;
        #1;
        chk("mid rst phase", 64'(dif.phase), 64'd0);
        chk("mid rst grant", 64'(dif.grant), 64'd0);
        chk("mid rst first", 64'(dif.isFirstPacketClock), 64'd0);
        chk("mid rst header", 64'(dif.header), 64'd0);
        chk("mid rst sp1", 64'(dif.subpacket1), 64'd0);
        chk("mid rst sent", 64'(dif.packetsSent), 64'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // pointer back at NUM_REQ-1 after reset: requester 0 wins, one slot
        dif.req = 4'b1111;
        run_island(5'd1, 1, 0, 1, 1'b0, -1, -1);
        step();

        // req = 0110 held: alternates in round-robin, always 0010 in fixed priority
        dif.req = 4'b0110;
        run_island(5'd4, 4, 1, FIXED ? 1 : 2, 1'b0, -1, -1);
        dif.req = 4'b0000;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_island_scheduler.md
# data_island_scheduler

Sequences HDMI data island periods during horizontal/vertical blanking and shares the packet serializer between several packet sources (audio sample, audio clock regeneration, InfoFrame generators). Sits between the video timing generator, the packet sources and the data island packet serializer. Drives the serializer's first-packet-clock strobe and packet contents, and drives the period code used by the TMDS channel mux.

## Interface
- `NUM_REQ`, default 4: number of packet requesters, 1..8.
- `MAX_PACKETS`, default 18: packet limit per island; the HDMI maximum is 18.
- `clock  in  1`: pixel clock.
- `reset  in  1`: asynchronous, active-high reset.
- `islandAllowed  in  1`: one-cycle pulse from the timing generator; a data island window opens.
- `islandSlots  in  5`: packets that fit in the window. Sampled with `islandAllowed`.
- `req  in  NUM_REQ`: requester i has a packet pending. Level signal.
- `pktHeader  in  NUM_REQ*24`: packed headers; requester i occupies bits [24i+23:24i].
- `pktBody  in  NUM_REQ*224`: packed subpackets 0..3. Requester i occupies bits [224i+223:224i], with subpacket0 in the low 56 bits.
- `grant  out  NUM_REQ`: one-hot, one-cycle pulse; the requester's packet has been captured.
- `isFirstPacketClock  out  1`: high on the first of the 32 clocks of each packet.
- `header  out  24`: packet contents to the serializer, held for 32 clocks.
- `subpacket0`..`subpacket3  out  56 each`: packet contents to the serializer, held for 32 clocks.
- `phase  out  3`: period code.
  - 0 CONTROL
  - 1 PREAMBLE
  - 2 LEAD_GUARD
  - 3 PACKET
  - 4 TRAIL_GUARD
- `packetsSent  out  5`: number of packets in the current or last island.

## Operation
- FSM states are IDLE, PREAMBLE, LEAD_GUARD, PACKET and TRAIL_GUARD. A phase counter `cnt` of 5 bits sets the length of each state:
  - PREAMBLE: 8 cycles.
  - LEAD_GUARD: 2 cycles.
  - PACKET: 32 cycles per packet.
  - TRAIL_GUARD: 2 cycles.
- IDLE to PREAMBLE requires all of:
  - `islandAllowed` is 1;
  - `|req` is 1;
  - the clamped slot count is at least 1.
- Slot count handling:
  - Clamped slot count = min(`islandSlots`, `MAX_PACKETS`); it loads `slotsLeft`.
  - `islandSlots` = 0 means no island is opened.
- `islandAllowed` is ignored in every state except IDLE.
- Arbitration point: the last cycle of LEAD_GUARD, and the last cycle (`cnt` = 31) of each PACKET.
  - At the first packet's arbitration point a packet is always produced. If a requester wins, its header and body are registered into the outputs. If `req` = 0, a null packet (header 24'h000000, all subpackets zero) is registered and no grant is issued.
  - At later arbitration points, if `slotsLeft` > 0 and `|req` is 1, arbitrate again and stay in PACKET. Otherwise go to TRAIL_GUARD.
  - Each packet start decrements `slotsLeft` and increments `packetsSent`.
- Arbitration is round-robin: search starts at the requester after the last winner. The last-winner pointer resets to NUM_REQ-1, so requester 0 is first after reset.
- Requester obligations:
  - Payload must be stable while `req` is high.
  - After its grant, a requester drops `req` or presents its next packet.
  - A requester granted while still asserting `req` is eligible at the next arbitration point.
- After TRAIL_GUARD, return to IDLE with `phase` = 0.
- Reset mid-island: outputs return to reset values immediately and the FSM goes to IDLE. The truncated island is not resumed.

## Timing
- Output reset values:
  - `grant` = 0, `isFirstPacketClock` = 0, `phase` = 0, `packetsSent` = 0.
  - `header` and all subpackets = 0.
  - Round-robin pointer = NUM_REQ-1.
- All outputs are registered.
- With `islandAllowed` sampled at cycle 0:
  - Cycles 1–8: `phase` = 1.
  - Cycles 9–10: `phase` = 2; arbitration occurs at cycle 10.
  - Cycle 11: packet 1 begins. `isFirstPacketClock` = 1, `grant` pulse, payload valid; `phase` = 3 through cycle 42.
  - Packet k starts at cycle 11 + 32(k−1).
- An island of N packets holds `phase` = 4 at cycles 11+32N and 12+32N, and returns to `phase` = 0 at cycle 13+32N.
- `grant` and `isFirstPacketClock` are coincident. Payload outputs change only on cycles where `isFirstPacketClock` = 1.

## Configuration
- `DATA_ISLAND_SCHEDULER_FIXED_PRIORITY_EN`:
  - Defined: fixed priority, lowest index wins, and the round-robin pointer is removed.
  - Undefined (default): round-robin as specified above.

## Test plan
- Single packet: `req` = 4'b0001, `islandAllowed` with `islandSlots` = 5 at cycle 0, `req` dropped after grant.
  - Expect `phase` sequence 1×8, 2×2, 3×32, 4×2, then 0.
  - Expect `grant` = 0001 and `isFirstPacketClock` at cycle 11; `packetsSent` = 1.
- Round-robin: `req` = 4'b1111 held, `islandSlots` = 6.
  - Expect grants 0001, 0010, 0100, 1000, 0001, 0010 at cycles 11, 43, 75, 107, 139, 171, then TRAIL_GUARD at 203.
- Slot clamp: `islandSlots` = 25 with `req` held.
  - Expect exactly 18 packets and `packetsSent` = 18.
- Null insert and ignored pulse:
  - `req` deasserts at cycle 5 of PREAMBLE: expect null packet at cycle 11, no grant, then trailing guard.
  - `islandSlots` = 0: expect no island.
- Reset and busy pulse:
  - Async `reset` asserted at cycle 50 of an island: expect `phase` = 0, `grant` = 0, payload = 0 before the next clock edge.
  - `islandAllowed` pulsed while in PACKET: expect it ignored.
- Fixed priority: build with `DATA_ISLAND_SCHEDULER_FIXED_PRIORITY_EN`, `req` = 4'b0110 held.
  - Expect every grant = 0010.
